// File: rtl/vend_pkg.sv
// vend_pkg: coin codes, buffer states and debounce defaults shared by the coin
// acceptor and the vending FSM.
package vend_pkg;
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1 = 2'b01;
  localparam logic [1:0] COIN_2 = 2'b10;
  localparam logic [1:0] COIN_3 = 2'b11;
  localparam int DEB_CYCLES_DEF = 4;
  localparam int CNT_W_DEF = 3;
  typedef enum logic {EMPTY, FULL} buf_state_e;
  function automatic logic [1:0] coin_of(input logic [2:0] ev);
    return ev[0] ? COIN_1 : ev[1] ? COIN_2 : ev[2] ? COIN_3 : COIN_NONE;
  endfunction
  function automatic logic multi_of(input logic [2:0] ev);
    return (ev[0] & ev[1]) | (ev[0] & ev[2]) | (ev[1] & ev[2]);
  endfunction
endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: one sensor line -- two-flop synchroniser, counting debouncer
// and a one-cycle pulse on each debounced rising edge.
module coin_debounce #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W = 3
) (
  input  logic Clk,
  input  logic Reset,
  input  logic raw,
  output logic rise
);
  logic meta_q, s_q, stable_q, stable_d, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = '0;
    stable_d = stable_q;
    if (s_q != stable_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) stable_d = s_q;
      else cnt_d = cnt_q + CNT_W'(1);
    end
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      meta_q <= 1'b0;
      s_q <= 1'b0;
      stable_q <= 1'b0;
      prev_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      meta_q <= raw;
      s_q <= meta_q;
      stable_q <= stable_d;
      prev_q <= stable_q;
      cnt_q <= cnt_d;
    end
  end
  assign rise = stable_q & ~prev_q;
endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: conditions three coin sensors, encodes accepted coins as
// one-cycle codes and holds one coin while the vending FSM is busy.
module coin_acceptor
  import vend_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] Sense,
  input  logic       Busy,
  output logic [1:0] Code,
  output logic       Reject,
  output logic       Pending
);
  logic [2:0] ev;
  logic [1:0] coin, held_q, held_d, code_q, code_d;
  logic multi, single, blocked, rej_q, rej_d;
  buf_state_e state_q, state_d;
  for (genvar i = 0; i < 3; i++) begin : g_deb
    coin_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb (
      .Clk(Clk), .Reset(Reset), .raw(Sense[i]), .rise(ev[i])
    );
  end
  assign coin = coin_of(ev);
  assign multi = multi_of(ev);
  assign single = |ev & ~multi;
  // The cycle after any code is treated like Busy so codes never touch.
  assign blocked = Busy | (code_q != COIN_NONE);
  always_comb begin
    state_d = state_q;
    held_d = held_q;
    code_d = COIN_NONE;
    rej_d = multi;
    if (state_q == FULL && !blocked) begin
      code_d = held_q;
      state_d = single ? FULL : EMPTY;
      held_d = single ? coin : held_q;
    end else if (state_q == FULL) begin
      rej_d = multi | single;
    end else if (single) begin
      state_d = blocked ? FULL : EMPTY;
      held_d = blocked ? coin : held_q;
      code_d = blocked ? COIN_NONE : coin;
    end
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= EMPTY;
      held_q <= COIN_NONE;
      code_q <= COIN_NONE;
      rej_q <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q <= held_d;
      code_q <= code_d;
      rej_q <= rej_d;
    end
  end
  assign Code = code_q;
  assign Reject = rej_q;
  assign Pending = (state_q == FULL);
endmodule
